// File: rtl/column_stack.sv
// Single-column piece stack: edge-triggered drop/undo commands, a falling-piece
// animation that walks down from the top row, and a committed red/black occupancy map.
module column_stack #(
  parameter int          ROWS         = 6,
  parameter logic [9:0]  COL_X        = 10'd525,
  parameter logic [9:0]  BASE_Y       = 10'd450,
  parameter logic [9:0]  ROW_PITCH    = 10'd50,
  parameter logic [7:0]  KEY_RED      = 8'h24,
  parameter logic [7:0]  KEY_BLACK    = 8'h18,
  parameter logic [7:0]  KEY_UNDO     = 8'h05,
  parameter int          ENFORCE_TURN = 1
) (
  input  logic            frame_clk,
  input  logic            Reset,
  input  logic [7:0]      keycode,
  output logic [ROWS-1:0] red,
  output logic [ROWS-1:0] black,
  output logic [3:0]      height,
  output logic            full,
  output logic            turn_black,
  output logic            busy,
  output logic            anim_black,
  output logic [9:0]      anim_x,
  output logic [9:0]      anim_y,
  output logic [9:0]      colX,
  output logic [9:0]      colY,
  output logic            drop_err,
  output logic            back,
  output logic            state_dbg
);

  localparam logic       ST_IDLE = 1'b0;
  localparam logic       ST_FALL = 1'b1;
  localparam logic [3:0] TOP_ROW = 4'(ROWS - 1);
  localparam logic [3:0] ROWS4   = 4'(ROWS);

  // Handshake: there is none; keycode is sampled every frame and a command
  // fires only on a change versus the previous frame's value.
  logic            state_q, state_d;
  logic [7:0]      key_prev_q, key_prev_d;
  logic [ROWS-1:0] red_q, red_d;
  logic [ROWS-1:0] black_q, black_d;
  logic [3:0]      height_q, height_d;
  logic [3:0]      anim_row_q, anim_row_d;
  logic            turn_q, turn_d;
  logic            anim_black_q, anim_black_d;
  logic            err_q, err_d;
  logic            back_q, back_d;

  logic            key_edge;
  logic            is_drop;
  logic            key_is_black;
  logic            full_now;
  logic [3:0]      undo_row;

  assign key_edge     = (keycode != key_prev_q);
  assign key_is_black = (keycode == KEY_BLACK);
  assign is_drop      = (keycode == KEY_RED) || key_is_black;
  assign full_now     = (height_q == ROWS4);
  assign undo_row     = height_q - 4'd1;

  always_comb begin
    state_d      = state_q;
    key_prev_d   = keycode;
    red_d        = red_q;
    black_d      = black_q;
    height_d     = height_q;
    anim_row_d   = anim_row_q;
    turn_d       = turn_q;
    anim_black_d = anim_black_q;
    err_d        = 1'b0;
    back_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (key_edge && is_drop) begin
          if (full_now || ((ENFORCE_TURN != 0) && (key_is_black != turn_q))) begin
            err_d = 1'b1;
          end else begin
            state_d      = ST_FALL;
            anim_row_d   = TOP_ROW;
            anim_black_d = key_is_black;
          end
        end else if (key_edge && (keycode == KEY_UNDO)) begin
          if (height_q == 4'd0) begin
            err_d = 1'b1;
          end else begin
            for (int r = 0; r < ROWS; r++) begin
              if (4'(r) == undo_row) begin
                red_d[r]   = 1'b0;
                black_d[r] = 1'b0;
              end
            end
            height_d = undo_row;
            turn_d   = ~turn_q;
            back_d   = 1'b1;
          end
        end
      end
      ST_FALL: begin
        // The landing row is the current height; it cannot change mid-fall.
        if (anim_row_q <= height_q) begin
          for (int r = 0; r < ROWS; r++) begin
            if (4'(r) == height_q) begin
              if (anim_black_q) black_d[r] = 1'b1;
              else              red_d[r]   = 1'b1;
            end
          end
          height_d = height_q + 4'd1;
          turn_d   = ~turn_q;
          state_d  = ST_IDLE;
        end else begin
          anim_row_d = anim_row_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= ST_IDLE;
      key_prev_q   <= 8'h00;
      red_q        <= '0;
      black_q      <= '0;
      height_q     <= 4'd0;
      anim_row_q   <= 4'd0;
      turn_q       <= 1'b0;
      anim_black_q <= 1'b0;
      err_q        <= 1'b0;
      back_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      key_prev_q   <= key_prev_d;
      red_q        <= red_d;
      black_q      <= black_d;
      height_q     <= height_d;
      anim_row_q   <= anim_row_d;
      turn_q       <= turn_d;
      anim_black_q <= anim_black_d;
      err_q        <= err_d;
      back_q       <= back_d;
    end
  end

  assign red        = red_q;
  assign black      = black_q;
  assign height     = height_q;
  assign full       = full_now;
  assign turn_black = turn_q;
  assign busy       = (state_q == ST_FALL);
  assign anim_black = anim_black_q;
  assign anim_x     = COL_X;
  // Wraps modulo 1024 by design; the 10-bit product keeps the arithmetic in pixel width.
  assign anim_y     = busy ? (BASE_Y - ({6'd0, anim_row_q} * ROW_PITCH)) : BASE_Y;
  assign colX       = COL_X;
  assign colY       = BASE_Y;
  assign drop_err   = err_q;
  assign back       = back_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_column_stack.sv
// Bench for column_stack: hand sequences for reset, drop timing, fall-time
// key edges and mid-fall reset, then a table of IDLE commands through a scoreboard.
module tb_column_stack;

  localparam int ROWS = 6;
  localparam int W    = 22;

  logic            frame_clk = 1'b0;
  logic            Reset;
  logic [7:0]      keycode;
  logic [ROWS-1:0] red, black;
  logic [3:0]      height;
  logic            full, turn_black, busy, anim_black;
  logic [9:0]      anim_x, anim_y, colX, colY;
  logic            drop_err, back, state_dbg;

  column_stack #(.ROWS(ROWS)) dut (
    .frame_clk  (frame_clk),
    .Reset      (Reset),
    .keycode    (keycode),
    .red        (red),
    .black      (black),
    .height     (height),
    .full       (full),
    .turn_black (turn_black),
    .busy       (busy),
    .anim_black (anim_black),
    .anim_x     (anim_x),
    .anim_y     (anim_y),
    .colX       (colX),
    .colY       (colY),
    .drop_err   (drop_err),
    .back       (back),
    .state_dbg  (state_dbg)
  );

  // clock / reset
  always #5 frame_clk = ~frame_clk;

  typedef struct {
    logic [7:0] key;
    logic [5:0] red;
    logic [5:0] black;
    logic [3:0] height;
    logic       turn;
    logic       full;
    logic [1:0] errs;
    logic [1:0] backs;
  } vec_t;

  vec_t        vecs[16];
  logic [W-1:0] exp_q[$];
  logic [9:0]   ay_q[$];
  int           total_cnt = 0;
  int           pass_cnt  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic do_reset();
    Reset   = 1'b1;
    keycode = 8'h00;
    repeat (3) @(posedge frame_clk);
    #1;
    Reset = 1'b0;
    tick();
  endtask

  // Holds a key for 10 frames (longer than any fall), releases it, and
  // returns the resulting state plus the pulse counts seen.
  task automatic run_cmd(input logic [7:0] key, output logic [W-1:0] obs);
    int errs, backs;
    errs  = 0;
    backs = 0;
    keycode = key;
    for (int i = 0; i < 10; i++) begin
      tick();
      errs  += int'(drop_err);
      backs += int'(back);
    end
    keycode = 8'h00;
    tick();
    errs  += int'(drop_err);
    backs += int'(back);
    if (errs > 3)  errs  = 3;
    if (backs > 3) backs = 3;
    obs = {red, black, height, turn_black, full, 2'(errs), 2'(backs)};
  endtask

  initial begin
    logic [W-1:0] obs;
    logic [W-1:0] exp;
    int           busy_cycles;
    int           errs;

    vecs[0]  = '{8'h18, 6'b000000, 6'b000000, 4'd0, 1'b0, 1'b0, 2'd1, 2'd0};
    vecs[1]  = '{8'h05, 6'b000000, 6'b000000, 4'd0, 1'b0, 1'b0, 2'd1, 2'd0};
    vecs[2]  = '{8'h24, 6'b000001, 6'b000000, 4'd1, 1'b1, 1'b0, 2'd0, 2'd0};
    vecs[3]  = '{8'h24, 6'b000001, 6'b000000, 4'd1, 1'b1, 1'b0, 2'd1, 2'd0};
    vecs[4]  = '{8'h18, 6'b000001, 6'b000010, 4'd2, 1'b0, 1'b0, 2'd0, 2'd0};
    vecs[5]  = '{8'h24, 6'b000101, 6'b000010, 4'd3, 1'b1, 1'b0, 2'd0, 2'd0};
    vecs[6]  = '{8'h05, 6'b000001, 6'b000010, 4'd2, 1'b0, 1'b0, 2'd0, 2'd1};
    vecs[7]  = '{8'h24, 6'b000101, 6'b000010, 4'd3, 1'b1, 1'b0, 2'd0, 2'd0};
    vecs[8]  = '{8'h18, 6'b000101, 6'b001010, 4'd4, 1'b0, 1'b0, 2'd0, 2'd0};
    vecs[9]  = '{8'h24, 6'b010101, 6'b001010, 4'd5, 1'b1, 1'b0, 2'd0, 2'd0};
    vecs[10] = '{8'h18, 6'b010101, 6'b101010, 4'd6, 1'b0, 1'b1, 2'd0, 2'd0};
    vecs[11] = '{8'h24, 6'b010101, 6'b101010, 4'd6, 1'b0, 1'b1, 2'd1, 2'd0};
    vecs[12] = '{8'h18, 6'b010101, 6'b101010, 4'd6, 1'b0, 1'b1, 2'd1, 2'd0};
    vecs[13] = '{8'h3c, 6'b010101, 6'b101010, 4'd6, 1'b0, 1'b1, 2'd0, 2'd0};
    vecs[14] = '{8'h05, 6'b010101, 6'b001010, 4'd5, 1'b1, 1'b0, 2'd0, 2'd1};
    vecs[15] = '{8'h18, 6'b010101, 6'b101010, 4'd6, 1'b0, 1'b1, 2'd0, 2'd0};

    // reset values, checked while Reset is still high
    Reset   = 1'b1;
    keycode = 8'h00;
    repeat (3) @(posedge frame_clk);
    #1;
    check("rst_red", 32'(red), 32'd0);
    check("rst_black", 32'(black), 32'd0);
    check("rst_height", 32'(height), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_turn", 32'(turn_black), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_anim_y", 32'(anim_y), 32'd450);
    check("rst_err", 32'(drop_err), 32'd0);
    check("rst_back", 32'(back), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);
    check("const_anim_x", 32'(anim_x), 32'd525);
    check("const_colx", 32'(colX), 32'd525);
    check("const_coly", 32'(colY), 32'd450);
    Reset = 1'b0;
    tick();

    // first red drop, key held 10 frames: six busy frames stepping down
    for (int r = ROWS - 1; r >= 0; r--) ay_q.push_back(10'(450 - r * 50));
    keycode     = 8'h24;
    busy_cycles = 0;
    errs        = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      errs += int'(drop_err);
      if (busy) begin
        busy_cycles++;
        check("fall_anim_black", 32'(anim_black), 32'd0);
        if (ay_q.size() > 0) check($sformatf("fall_anim_y%0d", busy_cycles), 32'(anim_y), 32'(ay_q.pop_front()));
      end
    end
    check("fall_busy_cycles", busy_cycles, 6);
    check("fall_y_drained", ay_q.size(), 0);
    check("fall_red", 32'(red), 32'b000001);
    check("fall_black", 32'(black), 32'd0);
    check("fall_height", 32'(height), 32'd1);
    check("fall_turn", 32'(turn_black), 32'd1);
    check("fall_errs", errs, 0);
    check("fall_idle_y", 32'(anim_y), 32'd450);
    keycode = 8'h00;
    tick();

    // opposite key edge during a black fall is ignored
    keycode = 8'h18;
    tick();
    check("ign_busy", 32'(busy), 32'd1);
    check("ign_anim_black", 32'(anim_black), 32'd1);
    keycode = 8'h24;
    errs    = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      errs += int'(drop_err);
    end
    check("ign_errs", errs, 0);
    check("ign_red", 32'(red), 32'b000001);
    check("ign_black", 32'(black), 32'b000010);
    check("ign_height", 32'(height), 32'd2);
    check("ign_busy_end", 32'(busy), 32'd0);
    keycode = 8'h00;
    tick();

    // reset in the middle of a fall
    keycode = 8'h24;
    tick();
    tick();
    check("mid_busy", 32'(busy), 32'd1);
    Reset = 1'b1;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_red", 32'(red), 32'd0);
    check("mid_rst_black", 32'(black), 32'd0);
    check("mid_rst_height", 32'(height), 32'd0);
    check("mid_rst_turn", 32'(turn_black), 32'd0);
    check("mid_rst_anim_y", 32'(anim_y), 32'd450);
    keycode = 8'h00;
    tick();
    Reset = 1'b0;
    repeat (8) tick();
    check("mid_post_height", 32'(height), 32'd0);
    check("mid_post_red", 32'(red), 32'd0);
    check("mid_post_busy", 32'(busy), 32'd0);

    // command table through the scoreboard
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back({vecs[i].red, vecs[i].black, vecs[i].height, vecs[i].turn,
                       vecs[i].full, vecs[i].errs, vecs[i].backs});
      run_cmd(vecs[i].key, obs);
      exp = exp_q.pop_front();
      check($sformatf("vec%0d_key%02h", i, vecs[i].key), 32'(obs), 32'(exp));
    end

    // drop into the top row lands on the frame after acceptance
    run_cmd(8'h05, obs);
    check("top_undo_height", 32'(height), 32'd5);
    keycode = 8'h18;
    tick();
    check("top_busy", 32'(busy), 32'd1);
    check("top_anim_y", 32'(anim_y), 32'd200);
    check("top_height_pre", 32'(height), 32'd5);
    tick();
    check("top_busy_done", 32'(busy), 32'd0);
    check("top_height", 32'(height), 32'd6);
    check("top_black", 32'(black), 32'b101010);
    check("top_full", 32'(full), 32'd1);
    keycode = 8'h00;
    tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
